// File: rtl/pcie_phys_pkg.sv
// -----------------------------------------------------------------------------
// pcie_phys_pkg
// Shared definitions for the PCIe physical-layer blocks (pcie_ltssm_ctrl and
// the surrounding pcie_phys_top):
//   - ltssm_state_t : LTSSM state encoding, also visible on state_o
//   - TS_TYPE_TS1/2 : training-sequence type encoding on the TS type wires
//   - max_int       : elaboration-time helper for sizing counters
// -----------------------------------------------------------------------------
package pcie_phys_pkg;

  typedef enum logic [2:0] {
    ST_DETECT_QUIET  = 3'd0,
    ST_DETECT_ACTIVE = 3'd1,
    ST_POLL_ACTIVE   = 3'd2,
    ST_POLL_CONFIG   = 3'd3,
    ST_L0            = 3'd4
  } ltssm_state_t;

  localparam logic TS_TYPE_TS1 = 1'b0;
  localparam logic TS_TYPE_TS2 = 1'b1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pcie_lane_mask.sv
// -----------------------------------------------------------------------------
// pcie_lane_mask
// Combinational contiguous-lane mask: bit i of lane_mask is set only when
// lanes 0..i all report a detected receiver, so the result is the longest
// run of set bits starting at lane 0 (4'b1011 -> 4'b0011).
// Ports:
//   load_detect [NUM_LANES] in  : per-lane receiver-detected flags
//   lane_mask   [NUM_LANES] out : contiguous mask anchored at lane 0
// -----------------------------------------------------------------------------
module pcie_lane_mask #(
  parameter int NUM_LANES = 4
) (
  input  logic [NUM_LANES-1:0] load_detect,
  output logic [NUM_LANES-1:0] lane_mask
);

  // Each bit is an AND-reduction of all lower lanes; written per bit rather
  // than as a ripple chain so no bit of the vector depends on another bit.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      assign lane_mask[gi] = &load_detect[gi:0];
    end
  endgenerate

endmodule

// File: rtl/pcie_ltssm_ctrl.sv
// -----------------------------------------------------------------------------
// pcie_ltssm_ctrl
// Simplified PCIe LTSSM: Detect.Quiet -> Detect.Active -> Polling.Active ->
// Polling.Configuration -> L0. Moore machine: every output is decoded from
// the registered state, the latched lane mask and the latched gen3 flag.
// Ports:
//   clk_i, rst_i            in  : clock, asynchronous active-high reset
//   load_detect_i [LANES]   in  : per-lane receiver-detected flags
//   rx_ts_valid_i           in  : one aligned TS ordered set received
//   rx_ts_type_i            in  : 0=TS1, 1=TS2
//   tx_ts_req_o             out : request TS transmission
//   tx_ts_type_o            out : 0=TS1, 1=TS2
//   tx_ts_ack_i             in  : one TS sent (counted only while requested)
//   gen3_capable_i          in  : 128b/130b permitted, sampled on L0 entry
//   link_down_i             in  : retrain request
//   lane_active_o [LANES]   out : trained lane mask
//   en8b10b_o, en128b130b_o out : one-hot encoder select
//   link_up_o               out : link in L0
//   state_o [3]             out : current LTSSM state
// -----------------------------------------------------------------------------
module pcie_ltssm_ctrl
  import pcie_phys_pkg::*;
#(
  parameter int NUM_LANES           = 4,
  parameter int DETECT_QUIET_CYCLES = 12,
  parameter int POLL_TS_COUNT       = 8,
  parameter int TIMEOUT_CYCLES      = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_LANES-1:0] load_detect_i,
  input  logic                 rx_ts_valid_i,
  input  logic                 rx_ts_type_i,
  output logic                 tx_ts_req_o,
  output logic                 tx_ts_type_o,
  input  logic                 tx_ts_ack_i,
  input  logic                 gen3_capable_i,
  input  logic                 link_down_i,
  output logic [NUM_LANES-1:0] lane_active_o,
  output logic                 en8b10b_o,
  output logic                 en128b130b_o,
  output logic                 link_up_o,
  output logic [2:0]           state_o
);

  // One timer serves both the Detect.Quiet dwell and the Polling timeout,
  // since it is cleared on every state entry anyway.
  localparam int TMR_MAX = max_int(DETECT_QUIET_CYCLES, TIMEOUT_CYCLES);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  // TS counters must reach 2*POLL_TS_COUNT (TS2 sent in Polling.Config).
  localparam int CNT_W   = $clog2(2 * POLL_TS_COUNT + 1);

  localparam logic [TMR_W-1:0] DQ_LAST  = TMR_W'(DETECT_QUIET_CYCLES - 1);
  localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TS_GOAL  = CNT_W'(POLL_TS_COUNT);
  localparam logic [CNT_W-1:0] TS2_GOAL = CNT_W'(2 * POLL_TS_COUNT);

  ltssm_state_t         state_reg,  state_next;
  logic [TMR_W-1:0]     tmr_reg,    tmr_next;
  logic [CNT_W-1:0]     tx_cnt_reg, tx_cnt_next;
  logic [CNT_W-1:0]     rx_cnt_reg, rx_cnt_next;
  logic [NUM_LANES-1:0] mask_reg,   mask_next;
  logic                 gen3_reg,   gen3_next;

  logic [NUM_LANES-1:0] mask_det;
  logic                 tx_req;
  logic                 tx_type;
  logic                 link_up;
  logic [NUM_LANES-1:0] lane_active;
  logic                 tx_sent;

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [TMR_W-1:0] tmr_inc(input logic [TMR_W-1:0] v);
    return (&v) ? v : v + TMR_W'(1);
  endfunction

  pcie_lane_mask #(
    .NUM_LANES (NUM_LANES)
  ) u_lane_mask (
    .load_detect (load_detect_i),
    .lane_mask   (mask_det)
  );

  // ---------------------------------------------------------------------------
  // State and latch registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg  <= ST_DETECT_QUIET;
      tmr_reg    <= '0;
      tx_cnt_reg <= '0;
      rx_cnt_reg <= '0;
      mask_reg   <= '0;
      gen3_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      tmr_reg    <= tmr_next;
      tx_cnt_reg <= tx_cnt_next;
      rx_cnt_reg <= rx_cnt_next;
      mask_reg   <= mask_next;
      gen3_reg   <= gen3_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Moore output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    tx_req      = 1'b0;
    tx_type     = TS_TYPE_TS1;
    link_up     = 1'b0;
    lane_active = '0;
    case (state_reg)
      ST_POLL_ACTIVE: begin
        tx_req      = 1'b1;
        tx_type     = TS_TYPE_TS1;
        lane_active = mask_reg;
      end
      ST_POLL_CONFIG: begin
        tx_req      = 1'b1;
        tx_type     = TS_TYPE_TS2;
        lane_active = mask_reg;
      end
      ST_L0: begin
        link_up     = 1'b1;
        lane_active = mask_reg;
      end
      default: ;
    endcase
  end

  assign tx_ts_req_o   = tx_req;
  assign tx_ts_type_o  = tx_type;
  assign link_up_o     = link_up;
  assign lane_active_o = lane_active;
  assign en128b130b_o  = link_up & gen3_reg;
  assign en8b10b_o     = ~(link_up & gen3_reg);
  assign state_o       = state_reg;

  // An ack only means something while a TS is actually being requested.
  assign tx_sent = tx_req & tx_ts_ack_i;

  // ---------------------------------------------------------------------------
  // Next-state, counters and latches
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    tmr_next    = tmr_inc(tmr_reg);
    tx_cnt_next = tx_cnt_reg;
    rx_cnt_next = rx_cnt_reg;
    mask_next   = mask_reg;
    gen3_next   = gen3_reg;

    case (state_reg)
      ST_DETECT_QUIET: begin
        // link_down_i has nothing to abort here; the dwell simply runs out.
        if (tmr_reg == DQ_LAST) state_next = ST_DETECT_ACTIVE;
      end

      ST_DETECT_ACTIVE: begin
        if (link_down_i)           state_next = ST_DETECT_QUIET;
        else if (load_detect_i[0]) state_next = ST_POLL_ACTIVE;
        else                       state_next = ST_DETECT_QUIET;
      end

      ST_POLL_ACTIVE: begin
        // Sent TS1 and received TS of either type count independently.
        if (tx_sent)       tx_cnt_next = cnt_inc(tx_cnt_reg);
        if (rx_ts_valid_i) rx_cnt_next = cnt_inc(rx_cnt_reg);
        if (link_down_i)
          state_next = ST_DETECT_QUIET;
        else if (tx_cnt_reg >= TS_GOAL && rx_cnt_reg >= TS_GOAL)
          state_next = ST_POLL_CONFIG;
        else if (tmr_reg == TO_LAST)
          state_next = ST_DETECT_QUIET;
      end

      ST_POLL_CONFIG: begin
        // Only TS2 counts on receive; sent TS2 count only once a TS2 has
        // been received in an earlier cycle.
        if (rx_ts_valid_i && rx_ts_type_i == TS_TYPE_TS2)
          rx_cnt_next = cnt_inc(rx_cnt_reg);
        if (tx_sent && rx_cnt_reg != '0)
          tx_cnt_next = cnt_inc(tx_cnt_reg);
        if (link_down_i)
          state_next = ST_DETECT_QUIET;
        else if (rx_cnt_reg >= TS_GOAL && tx_cnt_reg >= TS2_GOAL)
          state_next = ST_L0;
        else if (tmr_reg == TO_LAST)
          state_next = ST_DETECT_QUIET;
      end

      ST_L0: begin
        if (link_down_i) state_next = ST_DETECT_QUIET;
      end

      default: state_next = ST_DETECT_QUIET;
    endcase

    // Fresh counters and timer in every state that is newly entered.
    if (state_next != state_reg) begin
      tmr_next    = '0;
      tx_cnt_next = '0;
      rx_cnt_next = '0;
    end

    // Lane mask: captured in Detect.Active, dropped whenever we fall back.
    if (state_next == ST_DETECT_QUIET)
      mask_next = '0;
    else if (state_reg == ST_DETECT_ACTIVE)
      mask_next = mask_det;

    // Encoding choice is frozen at L0 entry.
    if (state_reg == ST_POLL_CONFIG && state_next == ST_L0)
      gen3_next = gen3_capable_i;
  end

endmodule
